io_bus_master: RTL and testbench

//  Initiator side of the memory-mapped IO bus (AS_L/WE_L/IO_Select/Address/data/byte_enable).

---
 rtl/io_bus_master_if.sv | 43 ++++
 rtl/io_bus_master.sv | 199 +++++++++++++++++++
 tb/tb_io_bus_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_master_if.sv
// -----------------------------------------------------------------------------
// io_bus_master_if
// Groups the CPU load/store request channel and the memory-mapped IO bus
// (AS_L/WE_L/IO_Select/Address/data/byte_enable) of io_bus_master.
//   master modport : the bus initiator (io_bus_master itself)
//   slave  modport : whoever drives CPU requests and answers the bus
// CPU request handshake: a request transfers on a rising edge where
// cpu_req && cpu_ready; cpu_ready is high only while the initiator is idle,
// requests seen while it is low are dropped, never queued.
// -----------------------------------------------------------------------------
interface io_bus_master_if;
   // CPU side
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [1:0]  cpu_size;
   logic        cpu_unsigned;
   logic        cpu_ready;
   logic        cpu_done;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   // IO bus side
   logic        AS_L;
   logic        WE_L;
   logic        IO_Select;
   logic [31:0] Address;
   logic [31:0] Bus_data_out;
   logic [3:0]  byte_enable;
   logic [31:0] Bus_data_in;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_unsigned, Bus_data_in,
      output cpu_ready, cpu_done, cpu_rdata, cpu_err,
             AS_L, WE_L, IO_Select, Address, Bus_data_out, byte_enable
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_unsigned, Bus_data_in,
      input  cpu_ready, cpu_done, cpu_rdata, cpu_err,
             AS_L, WE_L, IO_Select, Address, Bus_data_out, byte_enable
   );
endinterface

// File: rtl/io_bus_master.sv
// -----------------------------------------------------------------------------
// io_bus_master
// Initiator of the memory-mapped IO bus. Turns one CPU load/store request into
// a timed bus cycle IDLE -> SETUP -> STROBE (x STROBE_CYCLES) -> RECOVER -> IDLE,
// steers write lanes, and aligns / sign- or zero-extends read data.
// Ports:
//   Clock   - rising-edge clock
//   Reset   - synchronous active-high reset; aborts any access in flight
//   bus     - io_bus_master_if.master (CPU request channel + IO bus)
//   state_o - current FSM state, for observation
// Parameters:
//   IO_REGION     - Address[31:16] value that selects IO space
//   STROBE_CYCLES - cycles AS_L is held low per access (1..15)
// Build option:
//   MISALIGN_TRAP_EN - when defined, misaligned half/word accesses skip the bus
//                      cycle and complete next cycle with cpu_err=1, rdata=0.
//                      When undefined, cpu_err is tied 0.
// -----------------------------------------------------------------------------
module io_bus_master #(
   parameter logic [15:0] IO_REGION     = 16'h0001,
   parameter int unsigned STROBE_CYCLES = 1
) (
   input  logic                   Clock,
   input  logic                   Reset,
   io_bus_master_if.master        bus,
   output logic [1:0]             state_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETUP   = 2'd1,
      S_STROBE  = 2'd2,
      S_RECOVER = 2'd3
   } state_t;

   // Counter counts down to zero; zero marks the last strobe cycle.
   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic        we_q;
   logic        unsigned_q;
   logic        as_l_q;
   logic        we_l_q;
   logic        io_sel_q;
   logic [31:0] addr_q;
   logic [31:0] dout_q;
   logic [3:0]  be_q;
   logic        done_q;
   logic [31:0] rdata_q;

   logic [3:0]  be_d;
   logic [31:0] dout_d;
   logic [31:0] shifted_d;
   logic [31:0] rdata_d;

   // Write lane steering, computed from the request as it is accepted.
   always_comb begin
      be_d   = 4'b0000;
      dout_d = 32'h0;
      case (bus.cpu_size)
         2'b00: begin
            be_d   = 4'b0001 << bus.cpu_addr[1:0];
            dout_d = {4{bus.cpu_wdata[7:0]}};
         end
         2'b01: begin
            be_d   = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
            dout_d = {2{bus.cpu_wdata[15:0]}};
         end
         default: begin
            be_d   = 4'b1111;
            dout_d = bus.cpu_wdata;
         end
      endcase
   end

   // Read alignment and extension from the latched size/lane.
   always_comb begin
      shifted_d = bus.Bus_data_in;
      rdata_d   = bus.Bus_data_in;
      case (size_q)
         2'b00: begin
            shifted_d = bus.Bus_data_in >> {lane_q, 3'b000};
            rdata_d   = {{24{shifted_d[7] & ~unsigned_q}}, shifted_d[7:0]};
         end
         2'b01: begin
            shifted_d = bus.Bus_data_in >> {lane_q[1], 4'b0000};
            rdata_d   = {{16{shifted_d[15] & ~unsigned_q}}, shifted_d[15:0]};
         end
         default: begin
            rdata_d = bus.Bus_data_in;
         end
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic misalign_d;
   logic err_q;

   assign misalign_d = ((bus.cpu_size == 2'b01) && bus.cpu_addr[0]) ||
                       (bus.cpu_size[1] && (bus.cpu_addr[1:0] != 2'b00));
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         size_q     <= 2'b00;
         lane_q     <= 2'b00;
         we_q       <= 1'b0;
         unsigned_q <= 1'b0;
         as_l_q     <= 1'b1;
         we_l_q     <= 1'b1;
         io_sel_q   <= 1'b0;
         addr_q     <= 32'h0;
         dout_q     <= 32'h0;
         be_q       <= 4'b0000;
         done_q     <= 1'b0;
         rdata_q    <= 32'h0;
`ifdef MISALIGN_TRAP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cpu_req) begin
                  size_q     <= bus.cpu_size;
                  lane_q     <= bus.cpu_addr[1:0];
                  we_q       <= bus.cpu_we;
                  unsigned_q <= bus.cpu_unsigned;
`ifdef MISALIGN_TRAP_EN
                  if (misalign_d) begin
                     // No bus cycle: bus outputs keep their previous values.
                     state_q <= S_RECOVER;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     rdata_q <= 32'h0;
                  end else begin
`else
                  begin
`endif
                     state_q  <= S_SETUP;
                     addr_q   <= bus.cpu_addr;
                     io_sel_q <= (bus.cpu_addr[31:16] == IO_REGION);
                     be_q     <= be_d;
                     dout_q   <= bus.cpu_we ? dout_d : 32'h0;
                     we_l_q   <= ~bus.cpu_we;
                  end
               end
            end
            S_SETUP: begin
               as_l_q  <= 1'b0;
               cnt_q   <= STROBE_LOAD;
               state_q <= S_STROBE;
            end
            S_STROBE: begin
               if (cnt_q == 4'd0) begin
                  as_l_q  <= 1'b1;
                  we_l_q  <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_RECOVER;
                  // Only loads update the returned data; stores leave it held.
                  if (!we_q) begin
                     rdata_q <= rdata_d;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               done_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
               err_q   <= 1'b0;
`endif
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_ready    = (state_q == S_IDLE);
   assign bus.cpu_done     = done_q;
   assign bus.cpu_rdata    = rdata_q;
   assign bus.AS_L         = as_l_q;
   assign bus.WE_L         = we_l_q;
   assign bus.IO_Select    = io_sel_q;
   assign bus.Address      = addr_q;
   assign bus.Bus_data_out = dout_q;
   assign bus.byte_enable  = be_q;
   assign state_o          = state_q;
`ifdef MISALIGN_TRAP_EN
   assign bus.cpu_err      = err_q;
`else
   assign bus.cpu_err      = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_master.sv
// -----------------------------------------------------------------------------
// tb_io_bus_master
// Two instances (STROBE_CYCLES=1 and 3) receive identical stimulus; each cycle
// of every transaction is compared against a transaction-level model that
// derives strobe timing, lane enables, steered data and load results from the
// bus rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_io_bus_master;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   io_bus_master_if bus1 ();
   io_bus_master_if bus3 ();
   logic [1:0] st1, st3;

   io_bus_master #(.IO_REGION(16'h0001), .STROBE_CYCLES(1)) dut1 (
      .Clock(clk), .Reset(rst), .bus(bus1), .state_o(st1)
   );
   io_bus_master #(.IO_REGION(16'h0001), .STROBE_CYCLES(3)) dut3 (
      .Clock(clk), .Reset(rst), .bus(bus3), .state_o(st3)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;

   logic        t_we;
   logic [31:0] t_addr;
   logic [31:0] t_wdata;
   logic [1:0]  t_size;
   logic        t_uns;
   logic        t_trap;
   logic [31:0] din_at [0:7];
   logic [31:0] hold [0:1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] exp_be();
      if (t_size == 2'd0) return 32'(1 << (t_addr % 4));
      if (t_size == 2'd1) return ((t_addr / 2) % 2 == 1) ? 32'hC : 32'h3;
      return 32'hF;
   endfunction

   function automatic logic [31:0] exp_dout();
      if (t_we == 1'b0) return 32'h0;
      if (t_size == 2'd0) return (t_wdata & 32'hFF) * 32'h0101_0101;
      if (t_size == 2'd1) return (t_wdata & 32'hFFFF) * 32'h0001_0001;
      return t_wdata;
   endfunction

   function automatic logic [31:0] load_result(input logic [31:0] din);
      logic [31:0] v;
      if (t_size == 2'd0) begin
         v = (din >> (8 * (t_addr % 4))) & 32'hFF;
         if (!t_uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (t_size == 2'd1) begin
         v = (din >> (16 * ((t_addr / 2) % 2))) & 32'hFFFF;
         if (!t_uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = din;
      end
      return v;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [31:0] addr);
      return ((size == 2'd1) && (addr % 2 != 0)) || ((size >= 2'd2) && (addr % 4 != 0));
   endfunction

   // Compare one instance at cycle k after acceptance (k>=1).
   task automatic check_dut(input int d, input int s, input int k,
                            input logic as_l, input logic we_l, input logic io,
                            input logic rdy, input logic done, input logic err,
                            input logic [31:0] adr, input logic [31:0] dout,
                            input logic [31:0] rd, input logic [3:0] be);
      logic  e_as, e_we, e_rdy, e_done, e_err;
      string p;
      p = (d == 0) ? "s1" : "s3";
      if (t_trap) begin
         e_as = 1'b1; e_we = 1'b1;
         e_done = (k == 1); e_err = (k == 1); e_rdy = (k >= 2);
         if (k == 1) hold[d] = 32'h0;
      end else begin
         e_as   = !(k >= 2 && k <= s + 1);
         e_we   = (k <= s + 1) ? !t_we : 1'b1;
         e_done = (k == s + 2);
         e_err  = 1'b0;
         e_rdy  = (k > s + 2);
         if (k == s + 2 && !t_we) hold[d] = load_result(din_at[s + 1]);
         check_eq({p, "_addr"}, adr, t_addr);
         check_eq({p, "_iosel"}, {31'b0, io}, {31'b0, (t_addr >> 16) == 32'd1});
         check_eq({p, "_be"}, {28'b0, be}, exp_be());
         check_eq({p, "_dout"}, dout, exp_dout());
      end
      check_eq({p, "_as_l"}, {31'b0, as_l}, {31'b0, e_as});
      check_eq({p, "_we_l"}, {31'b0, we_l}, {31'b0, e_we});
      check_eq({p, "_ready"}, {31'b0, rdy}, {31'b0, e_rdy});
      check_eq({p, "_done"}, {31'b0, done}, {31'b0, e_done});
      check_eq({p, "_err"}, {31'b0, err}, {31'b0, e_err});
      check_eq({p, "_rdata"}, rd, hold[d]);
   endtask

   task automatic check_rst(input string p, input logic as_l, input logic we_l, input logic io,
                            input logic rdy, input logic done, input logic err,
                            input logic [31:0] adr, input logic [31:0] dout,
                            input logic [31:0] rd, input logic [3:0] be);
      check_eq({p, "_rst_as_l"}, {31'b0, as_l}, 32'd1);
      check_eq({p, "_rst_we_l"}, {31'b0, we_l}, 32'd1);
      check_eq({p, "_rst_iosel"}, {31'b0, io}, 32'd0);
      check_eq({p, "_rst_ready"}, {31'b0, rdy}, 32'd1);
      check_eq({p, "_rst_done"}, {31'b0, done}, 32'd0);
      check_eq({p, "_rst_err"}, {31'b0, err}, 32'd0);
      check_eq({p, "_rst_addr"}, adr, 32'd0);
      check_eq({p, "_rst_dout"}, dout, 32'd0);
      check_eq({p, "_rst_rdata"}, rd, 32'd0);
      check_eq({p, "_rst_be"}, {28'b0, be}, 32'd0);
   endtask

   task automatic check_rst_both();
      check_rst("s1", bus1.AS_L, bus1.WE_L, bus1.IO_Select, bus1.cpu_ready, bus1.cpu_done,
                bus1.cpu_err, bus1.Address, bus1.Bus_data_out, bus1.cpu_rdata, bus1.byte_enable);
      check_rst("s3", bus3.AS_L, bus3.WE_L, bus3.IO_Select, bus3.cpu_ready, bus3.cpu_done,
                bus3.cpu_err, bus3.Address, bus3.Bus_data_out, bus3.cpu_rdata, bus3.byte_enable);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_inputs(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size,
                             input logic uns, input logic [31:0] din);
      bus1.cpu_req = req;   bus3.cpu_req = req;
      bus1.cpu_we = we;     bus3.cpu_we = we;
      bus1.cpu_addr = addr; bus3.cpu_addr = addr;
      bus1.cpu_wdata = wdata; bus3.cpu_wdata = wdata;
      bus1.cpu_size = size; bus3.cpu_size = size;
      bus1.cpu_unsigned = uns; bus3.cpu_unsigned = uns;
      bus1.Bus_data_in = din; bus3.Bus_data_in = din;
   endtask

   // One transaction; while busy, junk requests are offered and must be ignored.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         input bit rand_din, input logic [31:0] din_c);
      int junk_end;
      @(negedge clk);
      check_eq("s1_ready_idle", {31'b0, bus1.cpu_ready}, 32'd1);
      check_eq("s3_ready_idle", {31'b0, bus3.cpu_ready}, 32'd1);
      t_we = we; t_addr = addr; t_wdata = wdata; t_size = size; t_uns = uns;
`ifdef MISALIGN_TRAP_EN
      t_trap = is_misaligned(size, addr);
`else
      t_trap = 1'b0;
`endif
      din_at[0] = rand_din ? $urandom : din_c;
      set_inputs(1'b1, we, addr, wdata, size, uns, din_at[0]);
      junk_end = t_trap ? 1 : 3;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check_dut(0, 1, k, bus1.AS_L, bus1.WE_L, bus1.IO_Select, bus1.cpu_ready, bus1.cpu_done,
                   bus1.cpu_err, bus1.Address, bus1.Bus_data_out, bus1.cpu_rdata, bus1.byte_enable);
         check_dut(1, 3, k, bus3.AS_L, bus3.WE_L, bus3.IO_Select, bus3.cpu_ready, bus3.cpu_done,
                   bus3.cpu_err, bus3.Address, bus3.Bus_data_out, bus3.cpu_rdata, bus3.byte_enable);
         din_at[k] = rand_din ? $urandom : din_c;
         set_inputs((k <= junk_end), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), din_at[k]);
      end
   endtask

   // Reset asserted while both instances are in STROBE.
   task automatic do_reset_mid();
      @(negedge clk);
      set_inputs(1'b1, 1'b0, 32'h0001_0010, 32'h0, 2'd2, 1'b0, 32'h1234_5678);
      @(negedge clk);
      set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h1234_5678);
      @(negedge clk);
      check_eq("s1_mid_as_l", {31'b0, bus1.AS_L}, 32'd0);
      check_eq("s3_mid_as_l", {31'b0, bus3.AS_L}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      hold[0] = 32'h0;
      hold[1] = 32'h0;
      check_rst_both();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("s1_post_rst_done", {31'b0, bus1.cpu_done}, 32'd0);
         check_eq("s3_post_rst_done", {31'b0, bus3.cpu_done}, 32'd0);
         check_eq("s3_post_rst_as_l", {31'b0, bus3.AS_L}, 32'd1);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a;
      rst = 1'b1;
      set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
      hold[0] = 32'h0;
      hold[1] = 32'h0;
      repeat (3) @(negedge clk);
      check_rst_both();
      rst = 1'b0;

      do_txn(1'b1, 32'h0001_0008, 32'h0012_3456, 2'd2, 1'b0, 1'b0, 32'h0);
      do_txn(1'b0, 32'h0001_0001, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0000_8000);
      do_txn(1'b0, 32'h0001_0001, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0000_8000);
      do_txn(1'b1, 32'h0001_0006, 32'h0000_BEEF, 2'd1, 1'b0, 1'b0, 32'h0);
      do_txn(1'b0, 32'h0000_1000, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
      do_txn(1'b0, 32'h0001_0004, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0);
      do_txn(1'b0, 32'h0001_0002, 32'h0, 2'd1, 1'b0, 1'b1, 32'h0);
      do_txn(1'b0, 32'h0001_0002, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0);
      do_txn(1'b0, 32'h0001_0003, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0);
      do_reset_mid();

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: a = {16'h0001, 16'($urandom)};
            1: a = {16'h0000, 16'($urandom)};
            default: a = $urandom;
         endcase
         do_txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b1, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
